btn_cmd_gen: RTL and testbench

Front end for the run/stop control latch. Converts two raw, bouncing, asynchronous push-button inputs into clean single-cycle start/stop command pulses that drive the latch's start and stop inputs. Each button gets a two-flop synchronizer, a debounce state machine and press-edge detection. A command arbiter enforces stop-over-start priority and a start interlock.

---
 rtl/btn_pkg.sv | 19 +
 rtl/btn_cmd_gen_if.sv | 24 ++
 rtl/btn_debounce.sv | 91 +++++++++
 rtl/btn_cmd_gen.sv | 64 ++++++
 tb/tb_btn_cmd_gen.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/btn_pkg.sv
// Shared constants for the push-button command front end: debounce state
// encoding and default timing parameters.
package btn_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_HIGH = 2'd1;
  localparam logic [1:0] ST_PRESSED   = 2'd2;
  localparam logic [1:0] ST_WAIT_LOW  = 2'd3;

  // 10 ms at 50 MHz
  localparam int DEBOUNCE_CYCLES_DEF = 500000;
  localparam int CNT_W_DEF           = 19;

  // The button counts as held from acceptance of the press until the release is accepted.
  function automatic logic state_is_held(input logic [1:0] st);
    return (st == ST_PRESSED) || (st == ST_WAIT_LOW);
  endfunction

endpackage

// File: rtl/btn_cmd_gen_if.sv
// Signal bundle between the raw button inputs, the command outputs and the debug state taps.
interface btn_cmd_gen_if;
  // start/stop are single-cycle command strobes with no backpressure: a
  // strobe is valid for exactly the one cycle it is high and the consumer
  // must accept it then; there is no ready signal.
  logic       btn_start_raw;
  logic       btn_stop_raw;
  logic       start;
  logic       stop;
  logic       start_held;
  logic       stop_held;
  logic [1:0] start_state;
  logic [1:0] stop_state;

  modport master (
    output btn_start_raw, btn_stop_raw,
    input  start, stop, start_held, stop_held, start_state, stop_state
  );

  modport slave (
    input  btn_start_raw, btn_stop_raw,
    output start, stop, start_held, stop_held, start_state, stop_state
  );
endinterface

// File: rtl/btn_debounce.sv
// One button: two-flop synchronizer, four-state debounce FSM with a stability
// counter, and a registered single-cycle press pulse.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       raw,
  output logic       held,
  output logic       press,
  output logic [1:0] state
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // The counter only advances while below CNT_LAST, so it never wraps.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sync2_q) begin
          state_d = ST_WAIT_HIGH;
          cnt_d   = '0;
        end
      end
      ST_WAIT_HIGH: begin
        if (!sync2_q) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_PRESSED;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_PRESSED: begin
        if (!sync2_q) begin
          state_d = ST_WAIT_LOW;
          cnt_d   = '0;
        end
      end
      ST_WAIT_LOW: begin
        if (sync2_q) begin
          state_d = ST_PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign held  = state_is_held(state_q);
  assign press = press_q;
  assign state = state_q;

endmodule

// File: rtl/btn_cmd_gen.sv
// Start/stop command generator: two debounced buttons feeding a registered
// arbiter where stop always wins and a held stop blocks start.
module btn_cmd_gen
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input logic          clk,
  input logic          n_rst,
  btn_cmd_gen_if.slave bus
);

  logic start_press, stop_press;
  logic start_held_w, stop_held_w;
  logic start_q, start_d;
  logic stop_q, stop_d;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_start_db (
    .clk  (clk),
    .n_rst(n_rst),
    .raw  (bus.btn_start_raw),
    .held (start_held_w),
    .press(start_press),
    .state(bus.start_state)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_stop_db (
    .clk  (clk),
    .n_rst(n_rst),
    .raw  (bus.btn_stop_raw),
    .held (stop_held_w),
    .press(stop_press),
    .state(bus.stop_state)
  );

  // A start press coinciding with a stop press or a held stop is dropped, not deferred.
  always_comb begin
    stop_d  = stop_press;
    start_d = start_press && !stop_press && !stop_held_w;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      start_q <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      start_q <= start_d;
      stop_q  <= stop_d;
    end
  end

  assign bus.start      = start_q;
  assign bus.stop       = stop_q;
  assign bus.start_held = start_held_w;
  assign bus.stop_held  = stop_held_w;

endmodule

// File: tb/tb_btn_cmd_gen.sv
// Bench for btn_cmd_gen with a short debounce window; expected command pulses
// are queued at stimulus time and matched by a monitor on the falling edge.
module tb_btn_cmd_gen;
  import btn_pkg::*;

  localparam int DB  = 4;
  // Drive at a falling edge, first sampling rising edge next, pulse 7 edges later.
  localparam int LAT = DB + 4;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  btn_cmd_gen_if bus_if ();

  btn_cmd_gen #(
    .DEBOUNCE_CYCLES(DB),
    .CNT_W          (3)
  ) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus_if.slave)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;
  // {is_stop, cycle at which the pulse must be seen}
  logic [32:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_pulse(input logic is_stop);
    logic [31:0] at;
    at = 32'(cyc + LAT);
    exp_q.push_back({is_stop, at});
  endtask

  task automatic check_drained(input string tag);
    check(tag, 32'(exp_q.size()), 0);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [32:0] e;
    if (bus_if.start || bus_if.stop) begin
      check("exclusive", 32'(bus_if.start & bus_if.stop), 0);
      if (exp_q.size() == 0) begin
        check("spurious_start", 32'(bus_if.start), 0);
        check("spurious_stop", 32'(bus_if.stop), 0);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind_stop", 32'(bus_if.stop), 32'(e[32]));
        check("pulse_cycle", 32'(cyc), e[31:0]);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.btn_start_raw = 1'b0;
    bus_if.btn_stop_raw  = 1'b0;
    n_rst = 1'b0;
    tick(2);
    #1;
    check("rst_start", 32'(bus_if.start), 0);
    check("rst_stop", 32'(bus_if.stop), 0);
    check("rst_start_held", 32'(bus_if.start_held), 0);
    check("rst_stop_held", 32'(bus_if.stop_held), 0);
    check("rst_start_state", 32'(bus_if.start_state), 32'(ST_IDLE));
    tick(1);
    n_rst = 1'b1;
    tick(3);

    // 1: clean press
    expect_pulse(1'b0);
    bus_if.btn_start_raw = 1'b1;
    tick(20);
    check("t1_start_held", 32'(bus_if.start_held), 1);
    check("t1_state", 32'(bus_if.start_state), 32'(ST_PRESSED));
    check("t1_stop_held", 32'(bus_if.stop_held), 0);
    bus_if.btn_start_raw = 1'b0;
    tick(12);
    check("t1_released", 32'(bus_if.start_held), 0);
    check_drained("t1_drained");

    // 2: bouncing press
    for (int i = 0; i < 2; i++) begin
      bus_if.btn_start_raw = 1'b1;
      tick(2);
      bus_if.btn_start_raw = 1'b0;
      tick(2);
    end
    expect_pulse(1'b0);
    bus_if.btn_start_raw = 1'b1;
    tick(15);
    bus_if.btn_start_raw = 1'b0;
    tick(12);
    check_drained("t2_drained");

    // 3: short dip while pressed
    expect_pulse(1'b0);
    bus_if.btn_start_raw = 1'b1;
    tick(15);
    bus_if.btn_start_raw = 1'b0;
    tick(2);
    bus_if.btn_start_raw = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      check("t3_held_through_dip", 32'(bus_if.start_held), 1);
    end
    tick(8);
    bus_if.btn_start_raw = 1'b0;
    tick(12);
    check_drained("t3_drained");

    // 4: simultaneous press
    expect_pulse(1'b1);
    bus_if.btn_start_raw = 1'b1;
    bus_if.btn_stop_raw  = 1'b1;
    tick(15);
    check("t4_start_held", 32'(bus_if.start_held), 1);
    check("t4_stop_held", 32'(bus_if.stop_held), 1);
    bus_if.btn_start_raw = 1'b0;
    bus_if.btn_stop_raw  = 1'b0;
    tick(12);
    check_drained("t4_drained");

    // 5: interlock, then re-press after stop released
    expect_pulse(1'b1);
    bus_if.btn_stop_raw = 1'b1;
    tick(12);
    bus_if.btn_start_raw = 1'b1;
    tick(15);
    check("t5_both_held", 32'({bus_if.start_held, bus_if.stop_held}), 3);
    bus_if.btn_start_raw = 1'b0;
    tick(12);
    bus_if.btn_stop_raw = 1'b0;
    tick(14);
    check("t5_stop_released", 32'(bus_if.stop_held), 0);
    expect_pulse(1'b0);
    bus_if.btn_start_raw = 1'b1;
    tick(15);
    bus_if.btn_start_raw = 1'b0;
    tick(12);
    check_drained("t5_drained");

    // 6: reset while counting, button still held at release
    bus_if.btn_start_raw = 1'b1;
    tick(5);
    check("t6_counting", 32'(bus_if.start_state), 32'(ST_WAIT_HIGH));
    n_rst = 1'b0;
    #1;
    check("t6_rst_start", 32'(bus_if.start), 0);
    check("t6_rst_held", 32'(bus_if.start_held), 0);
    check("t6_rst_state", 32'(bus_if.start_state), 32'(ST_IDLE));
    tick(3);
    expect_pulse(1'b0);
    n_rst = 1'b1;
    tick(15);
    check("t6_held_after_rst", 32'(bus_if.start_held), 1);
    bus_if.btn_start_raw = 1'b0;
    tick(12);
    check_drained("t6_drained");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
